thumb_decode_pipe: RTL and testbench
====================================

Name: thumb_decode_pipe

Overview:
- Registered Thumb decode stage with valid/ready handshakes to fetch (upstream) and execute (downstream).
- Decodes the 16-bit subset plus the 32-bit BL pair using a two-state halfword sequencer.
- Fills in load/store offsets and sign-extends branch offsets.
- Supports a pipeline flush on taken branches; widths are parametrised.

Parameters:
- DATA_W, 32, width of num, in_pc, pc_out.
- REG_SEL_W, 4, width of register selects. Must be >=4 so that LR=14 is encodable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch halfword valid
- in_ready  out  1  decode can accept a halfword this cycle
- in_instr  in  16  instruction halfword
- in_pc  in  DATA_W  address of in_instr
- flush  in  1  discard held state and output; synchronous
- out_valid  out  1  decoded entry valid
- out_ready  in  1  execute accepts the entry
- uop  out  5  micro-op: 0 branch/none, 1 ADD, 2 SUB, 4 EOR, 5 CMP, 6 LSL, 8 MOV, 9 STR, 10 LDR, 11 BL
- num_to_rhs  out  1  num replaces the p0 operand
- num  out  DATA_W  immediate or branch offset (halfwords)
- pc_out  out  DATA_W  pc of the first halfword of the instruction
- sel_p0, sel_p1, sel_in  out  REG_SEL_W  operand and destination selects
- in_enable_reg  out  1  instruction writes sel_in
- branch_cond  out  4  condition; 4'b1111 = not a branch
- is_wide  out  1  entry came from a 32-bit pair
- explose  out  1  undefined or illegal instruction

Behaviour:
- Reset or flush (flush equivalent to reset):
  - out_valid=0, state=FIRST, stored prefix cleared.
  - All payload outputs 0 except branch_cond=4'b1111.
  - in_ready=0 during the reset/flush cycle; flush wins over any simultaneous transfer on either side.
- Handshake:
  - in_ready = !reset && !flush && (!out_valid || out_ready).
  - Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
  - While out_valid && !out_ready, all outputs hold stable.
  - On an output transfer with no new entry produced in that cycle, out_valid drops to 0.
- Latency: entry is registered 1 cycle after the input transfer of its final halfword. Full throughput: 1 entry/cycle when out_ready=1.
- Payload defaults every decode: 0, with branch_cond=4'b1111. 3-bit register fields are zero-extended to REG_SEL_W.
- State machine:
  - FIRST, halfword [15:11]=11110: store the prefix and its pc, go to WAIT_SECOND, produce no entry.
  - WAIT_SECOND, [15:11]=11111: emit BL.
    - uop=11, branch_cond=1110, sel_in=14, in_enable_reg=1, is_wide=1.
    - num = signext22({prefix[10:0], hw[10:0]}).
    - pc_out = prefix pc. Go to FIRST.
  - WAIT_SECOND, any other halfword: emit explose=1, uop=0, is_wide=1, pc_out = prefix pc. The halfword is consumed. Go to FIRST.
  - FIRST, 11111 alone: explose=1.
- Decode table (FIRST state); Rd=[2:0], Rm/Rn=[5:3]:
  - LSL imm: [15:11]=00000, imm5!=0. uop6, num=imm5, sel_p1=Rm, sel_in=Rd, num_to_rhs=1, wr=1.
  - MOV reg: [15:11]=00000, imm5=0. uop8, sel_p0=Rm, sel_in=Rd, wr=1.
  - ADD/SUB reg: [15:9]=0001100 / 0001101. sel_p0=[8:6], sel_p1=Rn, sel_in=Rd, wr=1.
  - ADD/SUB imm3: [15:9]=0001110 / 0001111. num=[8:6], sel_p1=Rn, sel_in=Rd, num_to_rhs=1, wr=1.
  - MOV/CMP/ADD/SUB imm8: [15:11]=00100/00101/00110/00111. num=[7:0], num_to_rhs=1.
    - MOV: sel_in=[10:8], wr=1.
    - CMP: sel_p1=[10:8], wr=0.
    - ADD/SUB: sel_p1=sel_in=[10:8], wr=1.
  - EOR: [15:6]=0100000001. uop4, sel_p0=sel_in=Rd, sel_p1=Rm, wr=1.
  - STR imm: [15:11]=01100. uop9, sel_p0=[2:0], sel_p1=Rn, num=imm5<<2, num_to_rhs=1, wr=0.
  - LDR imm: [15:11]=01101. uop10, sel_in=[2:0], sel_p1=Rn, num=imm5<<2, num_to_rhs=1, wr=1.
  - B cond: [15:12]=1101, cond=[11:8] not in {1110, 1111}. uop0, branch_cond=cond, num=signext8. Cond 1110/1111 → explose=1.
  - B: [15:11]=11100. uop0, branch_cond=1110, num=signext11.
  - Anything else: explose=1, wr=0.
- Sign extension is always to DATA_W; the imm5<<2 result is zero-extended.

Test Plan:
- Reset then 0x1888 (ADD r0,r1,r2) with out_ready=1 → next cycle out_valid=1, uop=1, sel_p0=2, sel_p1=1, sel_in=0, in_enable_reg=1, branch_cond=F.
- 0xE7FE at pc 0x100 → uop=0, branch_cond=E, num=0xFFFFFFFE, pc_out=0x100. Then 0xD1FC → branch_cond=1, num=0xFFFFFFFC.
- BL pair 0xF000 @0x200, 0xF802 @0x202 → single entry: uop=11, num=2, sel_in=14, is_wide=1, pc_out=0x200. No entry after the prefix.
- 0x6848 (LDR r0,[r1,#4]) with out_ready=0 for 3 cycles → in_ready=0, outputs stable, num=4. Release → entry accepted once.
- Prefix 0xF000 then flush → out_valid=0, state FIRST. A following 0x2005 → MOV, num=5, sel_in=0.
- Prefix 0xF000 followed by 0x2005 → explose=1, is_wide=1, consumed. 0xDE00 → explose=1.

Source files
------------

// File: rtl/thumb_decode_if.sv
// Fetch-to-decode and decode-to-execute signals for the Thumb decode stage.
// Valid/ready: a beat moves on a clock edge where valid && ready; the sender holds it stable until then.
interface thumb_decode_if #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0]          in_instr;
  logic [DATA_W-1:0]    in_pc;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           uop;
  logic                 num_to_rhs;
  logic [DATA_W-1:0]    num;
  logic [DATA_W-1:0]    pc_out;
  logic [REG_SEL_W-1:0] sel_p0;
  logic [REG_SEL_W-1:0] sel_p1;
  logic [REG_SEL_W-1:0] sel_in;
  logic                 in_enable_reg;
  logic [3:0]           branch_cond;
  logic                 is_wide;
  logic                 explose;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, uop, num_to_rhs, num, pc_out, sel_p0, sel_p1,
           sel_in, in_enable_reg, branch_cond, is_wide, explose
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, uop, num_to_rhs, num, pc_out, sel_p0, sel_p1,
           sel_in, in_enable_reg, branch_cond, is_wide, explose
  );
endinterface

// File: rtl/thumb_decode_pipe.sv
// Registered Thumb decode stage: 16-bit subset plus the BL halfword pair,
// with a two-state halfword sequencer and synchronous flush.
module thumb_decode_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  thumb_decode_if.slave  bus,
  output logic           state_dbg
);

  typedef enum logic {FIRST = 1'b0, WAIT_SECOND = 1'b1} state_t;

  typedef struct packed {
    logic [4:0]           uop;
    logic                 num_to_rhs;
    logic [DATA_W-1:0]    num;
    logic [DATA_W-1:0]    pc;
    logic [REG_SEL_W-1:0] sel_p0;
    logic [REG_SEL_W-1:0] sel_p1;
    logic [REG_SEL_W-1:0] sel_in;
    logic                 wr;
    logic [3:0]           cond;
    logic                 wide;
    logic                 explose;
  } entry_t;

  state_t            state;
  entry_t            q;
  entry_t            dec;
  logic              out_valid_q;
  logic [10:0]       prefix;
  logic [DATA_W-1:0] prefix_pc;
  logic              dec_prefix;
  logic [15:0]       hw;
  logic [21:0]       bl_off;
  logic              take;

  function automatic logic [REG_SEL_W-1:0] zx3(input logic [2:0] r);
    return REG_SEL_W'(r);
  endfunction

  assign hw     = bus.in_instr;
  assign bl_off = {prefix, hw[10:0]};
  assign bus.in_ready = !reset && !bus.flush && (!out_valid_q || bus.out_ready);
  assign take   = bus.in_valid && bus.in_ready;

  always_comb begin
    dec        = '0;
    dec.cond   = 4'hF;
    dec.pc     = bus.in_pc;
    dec_prefix = 1'b0;
    if (state == WAIT_SECOND) begin
      // Second half of a pair: reports against the prefix address either way.
      dec.wide = 1'b1;
      dec.pc   = prefix_pc;
      if (hw[15:11] == 5'b11111) begin
        dec.uop    = 5'd11;
        dec.cond   = 4'b1110;
        dec.sel_in = REG_SEL_W'(14);
        dec.wr     = 1'b1;
        dec.num    = {{(DATA_W-22){bl_off[21]}}, bl_off};
      end else begin
        dec.explose = 1'b1;
      end
    end else if (hw[15:11] == 5'b00000) begin
      dec.sel_in = zx3(hw[2:0]);
      dec.wr     = 1'b1;
      if (hw[10:6] != 5'd0) begin
        dec.uop        = 5'd6;
        dec.num        = DATA_W'(hw[10:6]);
        dec.sel_p1     = zx3(hw[5:3]);
        dec.num_to_rhs = 1'b1;
      end else begin
        dec.uop    = 5'd8;
        dec.sel_p0 = zx3(hw[5:3]);
      end
    end else if (hw[15:10] == 6'b000110) begin
      dec.uop    = hw[9] ? 5'd2 : 5'd1;
      dec.sel_p0 = zx3(hw[8:6]);
      dec.sel_p1 = zx3(hw[5:3]);
      dec.sel_in = zx3(hw[2:0]);
      dec.wr     = 1'b1;
    end else if (hw[15:10] == 6'b000111) begin
      dec.uop        = hw[9] ? 5'd2 : 5'd1;
      dec.num        = DATA_W'(hw[8:6]);
      dec.sel_p1     = zx3(hw[5:3]);
      dec.sel_in     = zx3(hw[2:0]);
      dec.num_to_rhs = 1'b1;
      dec.wr         = 1'b1;
    end else if (hw[15:13] == 3'b001) begin
      dec.num        = DATA_W'(hw[7:0]);
      dec.num_to_rhs = 1'b1;
      case (hw[12:11])
        2'b00: begin dec.uop = 5'd8; dec.sel_in = zx3(hw[10:8]); dec.wr = 1'b1; end
        2'b01: begin dec.uop = 5'd5; dec.sel_p1 = zx3(hw[10:8]); end
        2'b10: begin dec.uop = 5'd1; dec.sel_p1 = zx3(hw[10:8]);
                     dec.sel_in = zx3(hw[10:8]); dec.wr = 1'b1; end
        default: begin dec.uop = 5'd2; dec.sel_p1 = zx3(hw[10:8]);
                       dec.sel_in = zx3(hw[10:8]); dec.wr = 1'b1; end
      endcase
    end else if (hw[15:6] == 10'b0100000001) begin
      dec.uop    = 5'd4;
      dec.sel_p0 = zx3(hw[2:0]);
      dec.sel_in = zx3(hw[2:0]);
      dec.sel_p1 = zx3(hw[5:3]);
      dec.wr     = 1'b1;
    end else if (hw[15:12] == 4'b0110) begin
      // Word offsets are scaled by 4 and never sign-extended.
      dec.num        = DATA_W'({hw[10:6], 2'b00});
      dec.sel_p1     = zx3(hw[5:3]);
      dec.num_to_rhs = 1'b1;
      if (hw[11]) begin
        dec.uop    = 5'd10;
        dec.sel_in = zx3(hw[2:0]);
        dec.wr     = 1'b1;
      end else begin
        dec.uop    = 5'd9;
        dec.sel_p0 = zx3(hw[2:0]);
      end
    end else if (hw[15:12] == 4'b1101) begin
      if (hw[11:9] == 3'b111) begin
        dec.explose = 1'b1;
      end else begin
        dec.cond = hw[11:8];
        dec.num  = {{(DATA_W-8){hw[7]}}, hw[7:0]};
      end
    end else if (hw[15:11] == 5'b11100) begin
      dec.cond = 4'b1110;
      dec.num  = {{(DATA_W-11){hw[10]}}, hw[10:0]};
    end else if (hw[15:11] == 5'b11110) begin
      dec_prefix = 1'b1;
    end else begin
      dec.explose = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      state       <= FIRST;
      q           <= '0;
      q.cond      <= 4'hF;
      out_valid_q <= 1'b0;
      prefix      <= '0;
      prefix_pc   <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (take) begin
        if (dec_prefix) begin
          state     <= WAIT_SECOND;
          prefix    <= hw[10:0];
          prefix_pc <= bus.in_pc;
        end else begin
          state       <= FIRST;
          q           <= dec;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.uop           = q.uop;
  assign bus.num_to_rhs    = q.num_to_rhs;
  assign bus.num           = q.num;
  assign bus.pc_out        = q.pc;
  assign bus.sel_p0        = q.sel_p0;
  assign bus.sel_p1        = q.sel_p1;
  assign bus.sel_in        = q.sel_in;
  assign bus.in_enable_reg = q.wr;
  assign bus.branch_cond   = q.cond;
  assign bus.is_wide       = q.wide;
  assign bus.explose       = q.explose;
  assign state_dbg         = state;

endmodule

// File: tb/tb_thumb_decode_pipe.sv
// Table-driven bench for thumb_decode_pipe plus directed BL, stall and flush sequences.
module tb_thumb_decode_pipe;

  logic clk = 1'b0;
  logic reset;
  logic state_dbg;
  int   n_checks = 0;
  int   n_fail   = 0;

  thumb_decode_if #(.DATA_W(32), .REG_SEL_W(4)) bus ();

  thumb_decode_pipe #(.DATA_W(32), .REG_SEL_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [31:0] pc;
    logic [4:0]  uop;
    logic        rhs;
    logic [31:0] num;
    logic [3:0]  p0;
    logic [3:0]  p1;
    logic [3:0]  sin;
    logic        wr;
    logic [3:0]  cond;
    logic        wide;
    logic        ex;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic [15:0] i, input logic [31:0] pc,
                              input logic [4:0] uop, input logic rhs,
                              input logic [31:0] num, input logic [3:0] p0,
                              input logic [3:0] p1, input logic [3:0] sin,
                              input logic wr, input logic [3:0] cond,
                              input logic wide, input logic ex);
    vec_t v;
    v.instr = i; v.pc = pc; v.uop = uop; v.rhs = rhs; v.num = num;
    v.p0 = p0; v.p1 = p1; v.sin = sin; v.wr = wr; v.cond = cond;
    v.wide = wide; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_entry(input vec_t v, input string tag);
    chk({tag, ".out_valid"},   32'(bus.out_valid),     32'd1);
    chk({tag, ".uop"},         32'(bus.uop),           32'(v.uop));
    chk({tag, ".num_to_rhs"},  32'(bus.num_to_rhs),    32'(v.rhs));
    chk({tag, ".num"},         bus.num,                v.num);
    chk({tag, ".pc_out"},      bus.pc_out,             v.pc);
    chk({tag, ".sel_p0"},      32'(bus.sel_p0),        32'(v.p0));
    chk({tag, ".sel_p1"},      32'(bus.sel_p1),        32'(v.p1));
    chk({tag, ".sel_in"},      32'(bus.sel_in),        32'(v.sin));
    chk({tag, ".wr"},          32'(bus.in_enable_reg), 32'(v.wr));
    chk({tag, ".branch_cond"}, 32'(bus.branch_cond),   32'(v.cond));
    chk({tag, ".is_wide"},     32'(bus.is_wide),       32'(v.wide));
    chk({tag, ".explose"},     32'(bus.explose),       32'(v.ex));
  endtask

  task automatic drive(input logic [15:0] i, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = i;
    bus.in_pc    = pc;
  endtask

  // One halfword transfer; returns at the negedge after the capturing edge.
  task automatic send(input logic [15:0] i, input logic [31:0] pc);
    @(negedge clk);
    drive(i, pc);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(16'h1888, 32'h000, 5'd1,  1'b0, 32'h0,        4'd0, 4'd0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[0].p0 = 4'd2; vecs[0].p1 = 4'd1;
    vecs[1]  = mk(16'hE7FE, 32'h100, 5'd0,  1'b0, 32'hFFFFFFFE, 4'd0, 4'd0, 4'd0, 1'b0, 4'hE, 1'b0, 1'b0);
    vecs[2]  = mk(16'hD1FC, 32'h102, 5'd0,  1'b0, 32'hFFFFFFFC, 4'd0, 4'd0, 4'd0, 1'b0, 4'h1, 1'b0, 1'b0);
    vecs[3]  = mk(16'h6848, 32'h104, 5'd10, 1'b1, 32'h4,        4'd0, 4'd1, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[4]  = mk(16'h2005, 32'h106, 5'd8,  1'b1, 32'h5,        4'd0, 4'd0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[5]  = mk(16'h0088, 32'h108, 5'd6,  1'b1, 32'h2,        4'd0, 4'd1, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[6]  = mk(16'h0008, 32'h10A, 5'd8,  1'b0, 32'h0,        4'd1, 4'd0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[7]  = mk(16'h1A53, 32'h10C, 5'd2,  1'b0, 32'h0,        4'd1, 4'd2, 4'd3, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[8]  = mk(16'h1C8A, 32'h10E, 5'd1,  1'b1, 32'h2,        4'd0, 4'd1, 4'd2, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[9]  = mk(16'h2B7F, 32'h110, 5'd5,  1'b1, 32'h7F,       4'd0, 4'd3, 4'd0, 1'b0, 4'hF, 1'b0, 1'b0);
    vecs[10] = mk(16'h3580, 32'h112, 5'd1,  1'b1, 32'h80,       4'd0, 4'd5, 4'd5, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[11] = mk(16'h3E01, 32'h114, 5'd2,  1'b1, 32'h1,        4'd0, 4'd6, 4'd6, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[12] = mk(16'h4051, 32'h116, 5'd4,  1'b0, 32'h0,        4'd1, 4'd2, 4'd1, 1'b1, 4'hF, 1'b0, 1'b0);
    vecs[13] = mk(16'h67FF, 32'h118, 5'd9,  1'b1, 32'h7C,       4'd7, 4'd7, 4'd0, 1'b0, 4'hF, 1'b0, 1'b0);
    vecs[14] = mk(16'hDE00, 32'h11A, 5'd0,  1'b0, 32'h0,        4'd0, 4'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b1);
    vecs[15] = mk(16'hDF00, 32'h11C, 5'd0,  1'b0, 32'h0,        4'd0, 4'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b1);
    vecs[16] = mk(16'hF800, 32'h11E, 5'd0,  1'b0, 32'h0,        4'd0, 4'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b1);
    vecs[17] = mk(16'hB000, 32'h120, 5'd0,  1'b0, 32'h0,        4'd0, 4'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b1);
    vecs[18] = mk(16'hD780, 32'h122, 5'd0,  1'b0, 32'hFFFFFF80, 4'd0, 4'd0, 4'd0, 1'b0, 4'h7, 1'b0, 1'b0);

    // Clock/reset
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset.out_valid",   32'(bus.out_valid),   32'd0);
    chk("reset.branch_cond", 32'(bus.branch_cond), 32'hF);
    chk("reset.uop",         32'(bus.uop),         32'd0);
    chk("reset.num",         bus.num,              32'd0);
    chk("reset.state",       32'(state_dbg),       32'd0);
    chk("reset.in_ready_after", 32'(bus.in_ready), 32'd1);

    // Table pass: one halfword at a time
    foreach (vecs[k]) begin
      send(vecs[k].instr, vecs[k].pc);
      check_entry(vecs[k], $sformatf("vec%0d", k));
    end

    // Back-to-back burst at full throughput
    @(negedge clk);
    drive(vecs[7].instr, vecs[7].pc);
    for (int k = 8; k <= 10; k++) begin
      @(negedge clk);
      check_entry(vecs[k-1], $sformatf("burst%0d", k - 1));
      if (k < 10) drive(vecs[k].instr, vecs[k].pc);
      else bus.in_valid = 1'b0;
    end
    check_entry(vecs[9], "burst9_hold");
    @(negedge clk);
    chk("burst.drain", 32'(bus.out_valid), 32'd0);

    // BL pair, positive and negative offsets
    send(16'hF000, 32'h200);
    chk("bl.prefix_no_entry", 32'(bus.out_valid), 32'd0);
    chk("bl.prefix_state",    32'(state_dbg),     32'd1);
    send(16'hF802, 32'h202);
    check_entry(mk(16'h0, 32'h200, 5'd11, 1'b0, 32'h2, 4'd0, 4'd0, 4'd14, 1'b1, 4'hE, 1'b1, 1'b0), "bl_pos");
    chk("bl.state_back", 32'(state_dbg), 32'd0);
    @(negedge clk);
    chk("bl.once", 32'(bus.out_valid), 32'd0);
    send(16'hF7FF, 32'h210);
    send(16'hFFFF, 32'h212);
    check_entry(mk(16'h0, 32'h210, 5'd11, 1'b0, 32'hFFFFFFFF, 4'd0, 4'd0, 4'd14, 1'b1, 4'hE, 1'b1, 1'b0), "bl_neg");

    // Prefix followed by a non-suffix halfword, then back to single decode
    send(16'hF000, 32'h500);
    send(16'h2005, 32'h502);
    check_entry(mk(16'h0, 32'h500, 5'd0, 1'b0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0, 4'hF, 1'b1, 1'b1), "bad_pair");
    send(16'hDE00, 32'h504);
    check_entry(mk(16'h0, 32'h504, 5'd0, 1'b0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0, 4'hF, 1'b0, 1'b1), "after_bad");

    // Downstream stall holds the entry and blocks fetch
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(16'h6848, 32'h300);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) drive(16'h2005, 32'h302);
      chk($sformatf("stall%0d.out_valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d.in_ready", c),  32'(bus.in_ready),  32'd0);
      chk($sformatf("stall%0d.uop", c),       32'(bus.uop),       32'd10);
      chk($sformatf("stall%0d.num", c),       bus.num,            32'd4);
      chk($sformatf("stall%0d.pc_out", c),    bus.pc_out,         32'h300);
      chk($sformatf("stall%0d.sel_p1", c),    32'(bus.sel_p1),    32'd1);
    end
    bus.out_ready = 1'b1;
    #1 chk("stall.release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_entry(mk(16'h0, 32'h302, 5'd8, 1'b1, 32'h5, 4'd0, 4'd0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0), "after_stall");
    @(negedge clk);
    chk("stall.drain", 32'(bus.out_valid), 32'd0);

    // Flush discards a held prefix and wins over a simultaneous transfer
    send(16'hF000, 32'h400);
    chk("flush.prefix_state", 32'(state_dbg), 32'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    drive(16'hF802, 32'h402);
    #1 chk("flush.in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush.out_valid",   32'(bus.out_valid),   32'd0);
    chk("flush.state",       32'(state_dbg),       32'd0);
    chk("flush.branch_cond", 32'(bus.branch_cond), 32'hF);
    send(16'h2005, 32'h404);
    check_entry(mk(16'h0, 32'h404, 5'd8, 1'b1, 32'h5, 4'd0, 4'd0, 4'd0, 1'b1, 4'hF, 1'b0, 1'b0), "after_flush");
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    chk("flush_held.out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_held.uop",       32'(bus.uop),       32'd0);
    chk("flush_held.num",       bus.num,            32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
